// File: rtl/pixel_writer.sv
// pixel_writer
//   Buffers shaded pixels in a small FIFO and writes each one to the OCRAM
//   framebuffer through the write-only Avalon-MM master m1. A flush/done
//   handshake reports when every pixel accepted so far has landed in memory.
//
// Ports
//   clock, reset_n        sole clock (rising edge), async active-low reset
//   pix_valid/pix_ready   pixel handshake; pix_row/pix_col/pix_color payload
//   flush / done          drain request, one-cycle completion pulse
//   clear_err / oob_error clear / sticky flag for dropped out-of-range pixels
//   written_count         completed m1 transfers, wraps mod 2^16
//   m1_address, m1_writedata, m1_write, m1_waitrequest   Avalon-MM master
module pixel_writer #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] FB_BASE      = 32'h0800_0000,
  parameter int unsigned H_RESOLUTION = 320,
  parameter int unsigned V_RESOLUTION = 240
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_row,
  input  logic [8:0]  pix_col,
  input  logic [15:0] pix_color,
  input  logic        flush,
  output logic        done,
  input  logic        clear_err,
  output logic        oob_error,
  output logic [15:0] written_count,
  output logic [31:0] m1_address,
  output logic [15:0] m1_writedata,
  output logic        m1_write,
  input  logic        m1_waitrequest
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] color;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } state_t;

  entry_t      fifo_mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fifo_count, count_next;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  entry_t      out_q, out_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        oob_q, oob_d;
  logic        done_q, done_d;
  state_t      state_q, state_d;

  entry_t      new_entry;
  logic        in_range, accept, push, drop, complete, pop, drained;

  always_comb begin
    // Acceptance stage: address formation and range check
    new_entry.addr  = FB_BASE + {14'd0, pix_row, pix_col, 1'b0};
    new_entry.color = pix_color;
    in_range = ({23'd0, pix_col} < H_RESOLUTION) && ({24'd0, pix_row} < V_RESOLUTION);
    accept   = pix_valid && ready_q;
    push     = accept && in_range;
    drop     = accept && !in_range;

    // FIFO / output stage boundary: the head moves into the transfer
    // register whenever that register is free or is being freed this edge.
    fifo_count = wr_ptr_q - rd_ptr_q;
    complete   = busy_q && !m1_waitrequest;
    pop        = (fifo_count != '0) && (!busy_q || complete);
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    count_next = wr_ptr_d - rd_ptr_d;
    // Ready is registered from the next count, so a full FIFO stays closed
    // even on an edge where the head pops.
    ready_d    = (count_next != FULL_COUNT);
    busy_d     = pop || (busy_q && !complete);
    out_d      = pop ? fifo_mem_q[rd_ptr_q[AW-1:0]] : out_q;
    wcnt_d     = wcnt_q + {15'd0, complete};

    if (drop) begin
      oob_d = 1'b1;
    end else if (clear_err) begin
      oob_d = 1'b0;
    end else begin
      oob_d = oob_q;
    end

    // Flush tracking: judged on post-edge occupancy so done lands in the
    // cycle right after the final completion.
    drained = (count_next == '0) && !busy_d;
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          if (drained) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PENDING;
          end
        end
      end
      S_PENDING: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= '0;
      wcnt_q   <= '0;
      oob_q    <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
      wcnt_q   <= wcnt_d;
      oob_q    <= oob_d;
      done_q   <= done_d;
      state_q  <= state_d;
    end
  end

  assign pix_ready     = ready_q;
  assign done          = done_q;
  assign oob_error     = oob_q;
  assign written_count = wcnt_q;
  assign m1_address    = out_q.addr;
  assign m1_writedata  = out_q.color;
  assign m1_write      = busy_q;

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer
//   Directed scenarios with literal expectations plus a randomized run, all
//   continuously compared against a queue-based behavioural model.
module tb_pixel_writer;

  localparam int DEPTH = 8;
  localparam int HRES  = 320;
  localparam int VRES  = 240;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_row = '0;
  logic [8:0]  pix_col = '0;
  logic [15:0] pix_color = '0;
  logic        flush = 1'b0;
  logic        done;
  logic        clear_err = 1'b0;
  logic        oob_error;
  logic [15:0] written_count;
  logic [31:0] m1_address;
  logic [15:0] m1_writedata;
  logic        m1_write;
  logic        m1_waitrequest = 1'b0;

  int errors = 0;
  int checks = 0;

  pixel_writer #(
    .DEPTH(DEPTH), .FB_BASE(32'h0800_0000), .H_RESOLUTION(HRES), .V_RESOLUTION(VRES)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_color(pix_color),
    .flush(flush), .done(done),
    .clear_err(clear_err), .oob_error(oob_error),
    .written_count(written_count),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_write(m1_write),
    .m1_waitrequest(m1_waitrequest)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [15:0] c;
  } ent_t;

  ent_t        pend[$];      // every accepted, not yet written pixel (head may be in flight)
  bit          m_inflight, m_ready, m_oob, m_done, m_pflush;
  logic [15:0] m_cnt;
  bit          s_rst, s_valid, s_wait, s_flush, s_clear;
  int          s_row, s_col;
  logic [15:0] s_color;

  task automatic model_reset();
    pend.delete();
    m_inflight = 0; m_ready = 0; m_oob = 0; m_done = 0; m_pflush = 0; m_cnt = '0;
  endtask

  task automatic model_step();
    bit acc;
    ent_t e;
    acc = s_valid && m_ready;
    if (m_inflight && !s_wait) begin
      void'(pend.pop_front());
      m_cnt = m_cnt + 16'd1;
      m_inflight = 0;
    end
    if (!m_inflight && pend.size() > 0) m_inflight = 1;
    if (acc && s_col < HRES && s_row < VRES) begin
      e.a = 32'h0800_0000 + 32'(s_row) * 32'd1024 + 32'(s_col) * 32'd2;
      e.c = s_color;
      pend.push_back(e);
    end
    if (acc && !(s_col < HRES && s_row < VRES)) m_oob = 1;
    else if (s_clear) m_oob = 0;
    m_done = 0;
    if (s_flush) m_pflush = 1;
    if (m_pflush && pend.size() == 0) begin
      m_done = 1;
      m_pflush = 0;
    end
    m_ready = (pend.size() - int'(m_inflight)) < DEPTH;
  endtask

  // Compare process: outputs checked mid-cycle, model advanced on each edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset_n) model_reset();
      check("mdl_pix_ready", {31'd0, pix_ready}, {31'd0, m_ready});
      check("mdl_m1_write", {31'd0, m1_write}, {31'd0, m_inflight});
      check("mdl_written_count", {16'd0, written_count}, {16'd0, m_cnt});
      check("mdl_oob_error", {31'd0, oob_error}, {31'd0, m_oob});
      check("mdl_done", {31'd0, done}, {31'd0, m_done});
      if (m_inflight && pend.size() > 0) begin
        check("mdl_m1_address", m1_address, pend[0].a);
        check("mdl_m1_writedata", {16'd0, m1_writedata}, {16'd0, pend[0].c});
      end
      s_rst = reset_n; s_valid = pix_valid; s_wait = m1_waitrequest;
      s_flush = flush; s_clear = clear_err;
      s_row = int'(pix_row); s_col = int'(pix_col); s_color = pix_color;
      @(posedge clock);
      if (s_rst) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    int n;
    int dones;
    bit hit;
    bit wt;

    // Reset state
    cyc(1);
    check("rst_m1_write", {31'd0, m1_write}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_written_count", {16'd0, written_count}, 32'd0);
    check("rst_m1_address", m1_address, 32'd0);
    reset_n = 1'b1;
    cyc(1);
    check("ready_after_release", {31'd0, pix_ready}, 32'd1);

    // Single pixel, no stall
    pix_valid = 1'b1; pix_row = 8'd2; pix_col = 9'd5; pix_color = 16'hABCD;
    cyc(1);
    pix_valid = 1'b0;
    check("lat_no_write_yet", {31'd0, m1_write}, 32'd0);
    cyc(1);
    check("single_write", {31'd0, m1_write}, 32'd1);
    check("single_addr", m1_address, 32'h0800_080A);
    check("single_data", {16'd0, m1_writedata}, 32'h0000_ABCD);
    cyc(1);
    check("single_count", {16'd0, written_count}, 32'd1);
    check("single_idle", {31'd0, m1_write}, 32'd0);

    // Same pixel with three stalled cycles
    m1_waitrequest = 1'b1;
    pix_valid = 1'b1;
    cyc(1);
    pix_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      check("stall_write_held", {31'd0, m1_write}, 32'd1);
      check("stall_addr_held", m1_address, 32'h0800_080A);
      check("stall_count_held", {16'd0, written_count}, 32'd1);
      cyc(1);
    end
    m1_waitrequest = 1'b0;
    check("stall_data_held", {16'd0, m1_writedata}, 32'h0000_ABCD);
    cyc(1);
    check("stall_count", {16'd0, written_count}, 32'd2);
    check("stall_done_write", {31'd0, m1_write}, 32'd0);

    // Back-pressure fill, then sustained drain
    m1_waitrequest = 1'b1;
    pix_valid = 1'b1; pix_row = 8'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      pix_col = 9'(i * 3);
      pix_color = 16'($urandom);
      if (pix_ready) n++;
      cyc(1);
    end
    check("fill_accepted", n, 32'd9);
    check("fill_ready_low", {31'd0, pix_ready}, 32'd0);
    pix_valid = 1'b0;
    m1_waitrequest = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("b2b_write", {31'd0, m1_write}, 32'd1);
      cyc(1);
    end
    check("b2b_count", {16'd0, written_count}, 32'd11);
    check("b2b_idle", {31'd0, m1_write}, 32'd0);

    // Out-of-range drops
    pix_valid = 1'b1; pix_row = 8'd0; pix_col = 9'd320;
    cyc(1);
    pix_valid = 1'b0;
    check("oob_set", {31'd0, oob_error}, 32'd1);
    cyc(1);
    check("oob_no_write", {31'd0, m1_write}, 32'd0);
    check("oob_count", {16'd0, written_count}, 32'd11);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    check("oob_cleared", {31'd0, oob_error}, 32'd0);
    pix_valid = 1'b1; pix_row = 8'd240; pix_col = 9'd0; clear_err = 1'b1;
    cyc(1);
    pix_valid = 1'b0; clear_err = 1'b0;
    check("oob_clear_vs_drop", {31'd0, oob_error}, 32'd1);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;

    // Three pixels, flush, toggling waitrequest
    wt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pix_row = 8'(10 + i); pix_col = 9'(i); pix_color = 16'($urandom);
      m1_waitrequest = wt; wt = ~wt;
      cyc(1);
    end
    pix_valid = 1'b0;
    flush = 1'b1;
    m1_waitrequest = wt; wt = ~wt;
    cyc(1);
    flush = 1'b0;
    dones = 0; hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      if (!hit && written_count == 16'd14) begin
        hit = 1'b1;
        check("flush_done_after_last", {31'd0, done}, 32'd1);
      end
      m1_waitrequest = wt; wt = ~wt;
      cyc(1);
    end
    check("flush_last_seen", {31'd0, hit}, 32'd1);
    check("flush_done_once", dones, 32'd1);
    m1_waitrequest = 1'b0;

    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    check("flush_empty_done", {31'd0, done}, 32'd1);
    cyc(1);
    check("flush_empty_pulse", {31'd0, done}, 32'd0);

    // Reset in the middle of a stall with pixels queued
    m1_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1; pix_row = 8'd20; pix_col = 9'(i); pix_color = 16'($urandom);
      cyc(1);
    end
    pix_valid = 1'b0;
    cyc(1);
    reset_n = 1'b0;
    #1;
    check("arst_m1_write", {31'd0, m1_write}, 32'd0);
    check("arst_m1_address", m1_address, 32'd0);
    check("arst_m1_writedata", {16'd0, m1_writedata}, 32'd0);
    check("arst_count", {16'd0, written_count}, 32'd0);
    check("arst_pix_ready", {31'd0, pix_ready}, 32'd0);
    cyc(1);
    reset_n = 1'b1;
    m1_waitrequest = 1'b0;
    cyc(1);
    check("arst_ready_back", {31'd0, pix_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("arst_no_stale", {31'd0, m1_write}, 32'd0);
      cyc(1);
    end
    check("arst_count_zero", {16'd0, written_count}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_row = 8'($urandom_range(0, 249));
      pix_col = 9'($urandom_range(0, 339));
      pix_color = 16'($urandom);
      m1_waitrequest = ($urandom_range(0, 9) < 4);
      flush = ($urandom_range(0, 19) == 0);
      clear_err = ($urandom_range(0, 29) == 0);
      cyc(1);
    end
    pix_valid = 1'b0; flush = 1'b0; clear_err = 1'b0; m1_waitrequest = 1'b0;
    cyc(20);
    check("drain_idle", {31'd0, m1_write}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Buffers finished pixel colours from the shader array and writes them to the OCRAM framebuffer over the GPU's Avalon-MM master port (m1). Sits directly downstream of the shaders inside voxel_gpu and drives the m1 write-only master, absorbing OCRAM back-pressure (m1_waitrequest). Provides a flush/done handshake so the control unit can raise irq once a chunk's pixels have actually landed in memory.

## Interface
- DEPTH, 8: FIFO entries, power of two, ≥2
- FB_BASE, 'h08000000: framebuffer byte base address
- H_RESOLUTION, 320: valid columns (≤512)
- V_RESOLUTION, 240: valid rows (≤256)
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  shader offers a pixel
- pix_ready  out  1  pixel accepted on edge where pix_valid && pix_ready
- pix_row  in  8  pixel row
- pix_col  in  9  pixel column
- pix_color  in  16  RGB565 colour
- flush  in  1  one-cycle request: signal done when all accepted pixels are written
- done  out  1  one-cycle pulse answering flush
- clear_err  in  1  clears oob_error
- oob_error  out  1  sticky: an out-of-range pixel was dropped
- written_count  out  16  completed m1 transfers, wraps mod 2^16
- m1_address  out  32  byte address
- m1_writedata  out  16  colour
- m1_write  out  1  write request
- m1_waitrequest  in  1  slave stall

## Operation
- Address = FB_BASE + {pix_row, pix_col, 1'b0} (row stride 1024 B, 2 B/pixel); 32-bit add, carry discarded.
- Range check at acceptance: pix_col ≥ H_RESOLUTION or pix_row ≥ V_RESOLUTION → pixel consumed (handshake completes) but not queued; oob_error set. clear_err and a drop on the same edge → oob_error stays 1.
- FIFO: DEPTH entries of {address, colour}; pointers log2(DEPTH)+1 bits; pix_ready = FIFO count < DEPTH (no bypass when full, even if the head pops on the same edge).
- Output stage: one register holding the in-flight transfer (busy flag). Loaded from FIFO head when !busy or when the current transfer completes on that edge; FIFO pop and output-stage load occur on the same edge.
- Transfer completes on an edge with m1_write && !m1_waitrequest; written_count increments there.
- Flush FSM: IDLE → (flush) PENDING → (FIFO empty && !busy) pulse done, → IDLE. flush while PENDING ignored. Pixels accepted while PENDING must also drain before done.
- All outputs reset to 0; pix_ready 1 after reset release. Reset mid-transfer abandons the FIFO contents and the in-flight write.

## Timing
- Latency: pixel accepted at edge k with FIFO and output stage empty → m1_write high from edge k+1.
- While m1_write && m1_waitrequest: m1_address, m1_writedata, m1_write held stable.
- Back-to-back: completion at edge k with FIFO non-empty → next transfer presented from edge k, m1_write stays high; 1 write/cycle sustained when waitrequest low.
- done: registered, high exactly one cycle, the cycle after the edge on which the last transfer completes; flush while already empty and idle → done after the next edge.
- Simultaneous push and pop on non-full FIFO: count unchanged.
- m1_write is registered; no combinational path from m1_waitrequest or pix_valid to any output except none (pix_ready derives from registered count only).

## Test plan
- Single pixel row 2, col 5, colour 'hABCD, waitrequest 0 → one write, m1_address 'h0800080A, m1_writedata 'hABCD, written_count 1.
- Same pixel with waitrequest high 3 cycles → address/data/write held 3 cycles, completes on 4th, exactly one count.
- Waitrequest held high, pix_valid continuous → exactly DEPTH+1 = 9 accepted before pix_ready drops; release → 9 writes in order, back-to-back, written_count 9.
- col 320, row 0 → handshake completes, no m1_write, oob_error 1, written_count unchanged; clear_err → 0.
- 3 pixels then flush with waitrequest toggling → done pulses once, one cycle after 3rd completion; flush on empty → done next cycle.
- reset_n low mid-stall with 4 queued → all outputs 0 asynchronously; after release no stale writes, pix_ready 1.
